// File: rtl/ppu_pkg.sv
// Shared types and sizing for the RAM port arbiter.
// Holds the FSM state enum, address/length widths and starvation default.
package ppu_pkg;

  localparam int ADDR_W         = 8;
  localparam int LEN_W          = 4;
  localparam int CNT_W          = 4;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/burst_counter.sv
// Loader burst address/beat counter: load, wrap-increment, last-beat flag.
// Ports: clk, rst_n, load, inc, load_addr, load_len -> addr, last.
module burst_counter
  import ppu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [LEN_W-1:0] remain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      remain <= '0;
    end else if (load) begin
      addr   <= load_addr;
      remain <= load_len;
    end else if (inc) begin
      // 8-bit add wraps 0xFF -> 0x00 naturally
      addr   <= addr + 1'b1;
      remain <= remain - 1'b1;
    end
  end

  assign last = (remain == '0);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one ram256x8 port between the MEM stage and a byte-burst loader.
// Ports: mem_* pipeline side, ld_* loader side, ram_* RAM side, clk, R.
module ram_port_arbiter
  import ppu_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              R,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic              mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  input  logic              ld_req,
  input  logic              ld_rw,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [LEN_W-1:0]  ld_len,
  input  logic [7:0]        ld_wdata,
  output logic              ld_ack,
  output logic [7:0]        ld_rdata,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ram_E,
  output logic              ram_RW,
  output logic              ram_Size,
  output logic [ADDR_W-1:0] ram_Addd,
  output logic [31:0]       ram_DI,
  input  logic [31:0]       ram_DO
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [CNT_W-1:0]  starve_cnt;
  logic              rw_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              last_beat;
  logic              leave_idle;
  logic              in_burst;
  logic              burst_own;
  logic              mem_grant;
  logic              starve_hit;

  assign leave_idle = (state_q == IDLE) && ld_req;
  assign in_burst   = (state_q == BURST);
  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
  // R gating keeps the RAM quiet while reset is held
  assign burst_own  = R && in_burst;
  assign mem_grant  = R && !in_burst && mem_req;

  burst_counter u_cnt (
    .clk       (clk),
    .rst_n     (R),
    .load      (leave_idle),
    .inc       (in_burst),
    .load_addr (ld_addr),
    .load_len  (ld_len),
    .addr      (cur_addr),
    .last      (last_beat)
  );

  always_ff @(posedge clk or negedge R) begin
    if (!R) state_q <= IDLE;
    else    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (ld_req) state_d = mem_req ? PEND : BURST;
      PEND:  if (!mem_req || starve_hit) state_d = BURST;
      BURST: if (last_beat) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      starve_cnt <= '0;
      rw_q       <= 1'b0;
      ld_rdata   <= '0;
    end else begin
      if (leave_idle) begin
        rw_q       <= ld_rw;
        starve_cnt <= mem_req ? CNT_W'(1) : '0;
      end else if (state_q == PEND && state_d == PEND) begin
        starve_cnt <= starve_cnt + 1'b1;
      end else if (state_q != PEND) begin
        starve_cnt <= '0;
      end
      if (in_burst && !rw_q) ld_rdata <= ram_DO[7:0];
    end
  end

  always_comb begin
    ram_E     = 1'b0;
    ram_RW    = 1'b0;
    ram_Size  = 1'b0;
    ram_Addd  = '0;
    ram_DI    = '0;
    mem_rdata = '0;
    unique case (1'b1)
      burst_own: begin
        ram_E    = 1'b1;
        ram_RW   = rw_q;
        ram_Addd = cur_addr;
        ram_DI   = {24'h0, ld_wdata};
      end
      mem_grant: begin
        ram_E     = 1'b1;
        ram_RW    = mem_rw;
        ram_Size  = mem_size;
        ram_Addd  = mem_addr;
        ram_DI    = mem_wdata;
        mem_rdata = ram_DO;
      end
      default: ;
    endcase
    ld_ack    = burst_own;
    mem_stall = burst_own && mem_req;
    ld_busy   = (state_q != IDLE);
    ld_done   = (state_q == DONE);
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised + directed bench for ram_port_arbiter with a behavioural model.
// Drives a ram256x8 stand-in, compares every cycle, prints one summary.
module tb_ram_port_arbiter;

  localparam int SMAX = 4;

  logic        clk;
  logic        R;
  logic        mem_req, mem_rw, mem_size;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_stall;
  logic        ld_req, ld_rw;
  logic [7:0]  ld_addr;
  logic [3:0]  ld_len;
  logic [7:0]  ld_wdata;
  logic        ld_ack, ld_busy, ld_done;
  logic [7:0]  ld_rdata;
  logic        ram_E, ram_RW, ram_Size;
  logic [7:0]  ram_Addd;
  logic [31:0] ram_DI, ram_DO;

  ram_port_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .R(R),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .ld_req(ld_req), .ld_rw(ld_rw), .ld_addr(ld_addr),
    .ld_len(ld_len), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .ld_busy(ld_busy), .ld_done(ld_done),
    .ram_E(ram_E), .ram_RW(ram_RW), .ram_Size(ram_Size),
    .ram_Addd(ram_Addd), .ram_DI(ram_DI), .ram_DO(ram_DO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM stand-in: big-endian word access, async read
  bit [7:0] ram [256];
  always_comb begin
    if (ram_Size)
      ram_DO = {ram[ram_Addd], ram[ram_Addd + 8'd1],
                ram[ram_Addd + 8'd2], ram[ram_Addd + 8'd3]};
    else
      ram_DO = {24'h0, ram[ram_Addd]};
  end
  always @(posedge clk) begin
    if (ram_E && ram_RW) begin
      if (ram_Size) begin
        ram[ram_Addd]        <= ram_DI[31:24];
        ram[ram_Addd + 8'd1] <= ram_DI[23:16];
        ram[ram_Addd + 8'd2] <= ram_DI[15:8];
        ram[ram_Addd + 8'd3] <= ram_DI[7:0];
      end else begin
        ram[ram_Addd] <= ram_DI[7:0];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // model: 0 idle, 1 waiting for port, 2 transferring, 3 finishing
  int         m_st = 0;
  int         m_wait = 0;
  int         m_left = 0;
  logic [7:0] m_addr = '0;
  logic       m_rw = 1'b0;
  logic [7:0] m_rdata = '0;
  bit   [7:0] ref_m [256];

  int         n_ack, n_stall, n_done, n_pend;
  logic [7:0] ack_q[$];
  logic [7:0] rd_q[$];
  logic       prev_rd = 1'b0;
  logic [7:0] wtbl [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [7:0] a,
                                         input logic sz);
    if (sz)
      return {ref_m[a], ref_m[a + 8'd1], ref_m[a + 8'd2], ref_m[a + 8'd3]};
    return {24'h0, ref_m[a]};
  endfunction

  task automatic ref_wr(input logic [7:0] a, input logic sz,
                        input logic [31:0] d);
    if (sz) begin
      ref_m[a]        = d[31:24];
      ref_m[a + 8'd1] = d[23:16];
      ref_m[a + 8'd2] = d[15:8];
      ref_m[a + 8'd3] = d[7:0];
    end else begin
      ref_m[a] = d[7:0];
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_wait = 0; m_left = 0;
    m_addr = '0; m_rw = 1'b0; m_rdata = '0;
    prev_rd = 1'b0;
  endtask

  task automatic obs_clear();
    n_ack = 0; n_stall = 0; n_done = 0; n_pend = 0;
    ack_q.delete();
    rd_q.delete();
  endtask

  // Entered at posedge+1 with inputs set; compares, then advances one edge.
  task automatic cyc();
    logic        xfer, gr;
    logic        e_E, e_RW, e_Sz, e_stall;
    logic [7:0]  e_A;
    logic [31:0] e_DI, e_rd;
    #3;
    xfer = R && (m_st == 2);
    gr   = R && (m_st != 2) && mem_req;
    e_E = 0; e_RW = 0; e_Sz = 0; e_A = '0; e_DI = '0; e_rd = '0;
    if (xfer) begin
      e_E = 1; e_RW = m_rw; e_A = m_addr; e_DI = {24'h0, ld_wdata};
    end else if (gr) begin
      e_E = 1; e_RW = mem_rw; e_Sz = mem_size; e_A = mem_addr;
      e_DI = mem_wdata; e_rd = ref_rd(mem_addr, mem_size);
    end
    e_stall = xfer && mem_req;
    chk("ram_E", ram_E, e_E);
    chk("ram_RW", ram_RW, e_RW);
    chk("ram_Size", ram_Size, e_Sz);
    chk("ram_Addd", ram_Addd, e_A);
    chk("ram_DI", ram_DI, e_DI);
    chk("mem_rdata", mem_rdata, e_rd);
    chk("mem_stall", mem_stall, e_stall);
    chk("ld_ack", ld_ack, xfer);
    chk("ld_busy", ld_busy, m_st != 0);
    chk("ld_done", ld_done, m_st == 3);
    chk("ld_rdata", ld_rdata, m_rdata);
    if (prev_rd) rd_q.push_back(ld_rdata);
    prev_rd = ld_ack && !ram_RW;
    if (ld_ack) begin n_ack++; ack_q.push_back(ram_Addd); end
    if (mem_stall) n_stall++;
    if (ld_done) n_done++;
    if (ld_busy && !ld_ack && !ld_done) n_pend++;
    @(posedge clk);
    if (R) begin
      case (m_st)
        0: begin
          if (mem_req && mem_rw) ref_wr(mem_addr, mem_size, mem_wdata);
          if (ld_req) begin
            m_rw = ld_rw; m_addr = ld_addr; m_left = int'(ld_len) + 1;
            if (mem_req) begin m_st = 1; m_wait = 1; end
            else m_st = 2;
          end
        end
        1: begin
          if (mem_req && mem_rw) ref_wr(mem_addr, mem_size, mem_wdata);
          if (!mem_req || m_wait == SMAX) m_st = 2;
          else m_wait++;
        end
        2: begin
          if (m_rw) ref_m[m_addr] = ld_wdata;
          else m_rdata = ref_m[m_addr];
          m_addr = m_addr + 8'd1;
          m_left--;
          if (m_left == 0) m_st = 3;
        end
        default: begin
          if (mem_req && mem_rw) ref_wr(mem_addr, mem_size, mem_wdata);
          m_st = 0;
        end
      endcase
    end
    #1;
  endtask

  task automatic run_burst(input logic rw, input logic [7:0] a,
                           input logic [3:0] len, input logic mreq);
    int guard;
    guard = 0;
    ld_req = 1; ld_rw = rw; ld_addr = a; ld_len = len;
    mem_req = mreq; mem_rw = 0; mem_size = 1; mem_addr = 8'h20;
    ld_wdata = wtbl[0];
    cyc();
    ld_req = 0;
    ld_addr = 8'($urandom);
    ld_len = 4'($urandom);
    ld_rw = ~rw;
    while (m_st != 0 && guard < 60) begin
      ld_wdata = (m_st == 2) ? wtbl[int'(len) + 1 - m_left] : 8'h5A;
      cyc();
      guard++;
    end
    if (guard >= 60) chk("burst_timeout", 1, 0);
  endtask

  initial begin
    R = 0; mem_req = 0; mem_rw = 0; mem_size = 0;
    mem_addr = '0; mem_wdata = '0;
    ld_req = 0; ld_rw = 0; ld_addr = '0; ld_len = '0; ld_wdata = '0;
    foreach (wtbl[i]) wtbl[i] = 8'(i * 17 + 3);
    model_reset();
    obs_clear();
    #1;
    cyc();
    cyc();
    R = 1;
    cyc();

    // write burst at 0x10, then read it back
    obs_clear();
    wtbl[0] = 8'hAA; wtbl[1] = 8'hBB; wtbl[2] = 8'hCC; wtbl[3] = 8'hDD;
    run_burst(1'b1, 8'h10, 4'd3, 1'b0);
    chk("wr_acks", n_ack, 4);
    chk("wr_done", n_done, 1);
    chk("wr_addr0", ack_q.size() > 0 ? ack_q[0] : 8'hXX, 8'h10);
    chk("wr_addr3", ack_q.size() > 3 ? ack_q[3] : 8'hXX, 8'h13);
    chk("ram_10", ram[8'h10], 8'hAA);
    chk("ram_13", ram[8'h13], 8'hDD);
    obs_clear();
    run_burst(1'b0, 8'h10, 4'd3, 1'b0);
    chk("rd_cnt", rd_q.size(), 4);
    chk("rd_0", rd_q.size() > 0 ? rd_q[0] : 8'hXX, 8'hAA);
    chk("rd_1", rd_q.size() > 1 ? rd_q[1] : 8'hXX, 8'hBB);
    chk("rd_3", rd_q.size() > 3 ? rd_q[3] : 8'hXX, 8'hDD);

    // address wrap
    obs_clear();
    run_burst(1'b1, 8'hFE, 4'd2, 1'b0);
    chk("wrap_n", ack_q.size(), 3);
    chk("wrap_0", ack_q.size() > 0 ? ack_q[0] : 8'hXX, 8'hFE);
    chk("wrap_1", ack_q.size() > 1 ? ack_q[1] : 8'hXX, 8'hFF);
    chk("wrap_2", ack_q.size() > 2 ? ack_q[2] : 8'hXX, 8'h00);

    // pipeline holds the port, loader waits out the starvation bound
    obs_clear();
    run_burst(1'b1, 8'h40, 4'd3, 1'b1);
    chk("pend_cycles", n_pend, 4);
    chk("stall_cycles", n_stall, 4);
    mem_req = 1;
    cyc();
    chk("stall_after", n_stall, 4);

    // MEM word write then same-cycle read at 52
    mem_req = 1; mem_rw = 1; mem_size = 1;
    mem_addr = 8'd52; mem_wdata = 32'h1234_5678;
    cyc();
    mem_rw = 0;
    #3;
    chk("word52", mem_rdata, 32'h1234_5678);
    chk("word52_ack", ld_ack, 0);
    #2;
    @(posedge clk);
    #1;
    cyc();

    // reset during beat 2 of a 4-beat burst
    obs_clear();
    mem_req = 0;
    ld_req = 1; ld_rw = 1; ld_addr = 8'h80; ld_len = 4'd3;
    ld_wdata = 8'h11;
    cyc();
    ld_req = 0;
    cyc();
    ld_wdata = 8'h22;
    R = 0;
    model_reset();
    cyc();
    chk("rst_busy", ld_busy, 0);
    chk("rst_E", ram_E, 0);
    cyc();
    R = 1;
    cyc();
    cyc();
    chk("rst_nodone", n_done, 0);
    chk("rst_b1", ram[8'h80], 8'h11);
    chk("rst_b3", ram[8'h82], 8'h00);
    chk("rst_b4", ram[8'h83], 8'h00);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      mem_req   = ($urandom_range(0, 1) == 1);
      mem_rw    = 1'($urandom);
      mem_size  = 1'($urandom);
      mem_addr  = 8'($urandom);
      mem_wdata = $urandom;
      ld_req    = ($urandom_range(0, 4) == 0);
      ld_rw     = 1'($urandom);
      ld_addr   = 8'($urandom);
      ld_len    = 4'($urandom);
      ld_wdata  = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        R = 0;
        model_reset();
      end else begin
        R = 1;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter
Interface
REQ-001 STARVE_MAX, 4, SHALL set the maximum consecutive pipeline-granted cycles while a loader burst is pending (range 1..15).
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 R  in  1  SHALL be the reset, asynchronous and active-low.
REQ-004 mem_req  in  1  SHALL be the MEM-stage access request (the MEM_Enable_signal equivalent).
REQ-005 mem_rw  in  1  SHALL select the MEM-stage operation: 1 write, 0 read.
REQ-006 mem_size  in  1  SHALL select the MEM-stage access size: 1 word, 0 byte.
REQ-007 mem_addr  in  8  SHALL be the MEM-stage byte address.
REQ-008 mem_wdata  in  32  SHALL be the MEM-stage write data.
REQ-009 mem_rdata  out  32  SHALL return the MEM-stage read data, same cycle.
REQ-010 mem_stall  out  1  SHALL freeze the pipeline while the port is denied to the MEM stage.
REQ-011 ld_req  in  1  SHALL request a loader byte burst.
REQ-012 ld_rw  in  1  SHALL select the burst direction: 1 write, 0 read.
REQ-013 ld_addr  in  8  SHALL be the burst start address.
REQ-014 ld_len  in  4  SHALL give the burst length; beats = ld_len+1.
REQ-015 ld_wdata  in  8  SHALL be the write byte of the current beat.
REQ-016 ld_ack  out  1  SHALL mark a beat executing this cycle.
REQ-017 ld_rdata  out  8  SHALL hold the read byte, registered and valid the cycle after a read-beat ld_ack.
REQ-018 ld_busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-019 ld_done  out  1  SHALL be a one-cycle burst-complete pulse.
REQ-020 ram_E, ram_RW, ram_Size  out  1 each  SHALL drive the ram256x8 enable, write and size inputs.
REQ-021 ram_Addd  out  8  SHALL drive the RAM address.
REQ-022 ram_DI  out  32  SHALL drive the RAM write data.
REQ-023 ram_DO  in  32  SHALL carry the RAM asynchronous read data.
Function
REQ-024 FSM states SHALL be IDLE, PEND, BURST and DONE.
REQ-025 In IDLE, PEND and DONE the MEM stage SHALL own the port combinationally: ram_* = mem_*, ram_E = mem_req, mem_rdata = ram_DO, mem_stall = 0.
REQ-026 When no requester owns the port, ram_E and all other ram_* outputs SHALL be 0, and mem_rdata SHALL be 0 whenever the MEM stage is not granted.
REQ-027 IDLE: ld_req with !mem_req SHALL go to BURST; ld_req with mem_req SHALL go to PEND with starve_cnt=1; ld_rw, ld_addr and ld_len SHALL be latched on leaving IDLE.
REQ-028 PEND: the FSM SHALL go to BURST on the first edge where !mem_req or starve_cnt==STARVE_MAX, and SHALL otherwise increment starve_cnt.
REQ-029 BURST: exactly one byte beat per cycle with ld_ack=1, ram_Size=0, ram_Addd=current address and ram_DI={24'b0,ld_wdata}; mem_stall SHALL equal mem_req.
REQ-030 Burst address SHALL increment per beat modulo 256 (wrap 0xFF->0x00); after the last beat the FSM SHALL go to DONE.
REQ-031 DONE: ld_done=1 for one cycle, ld_req SHALL be ignored, and the FSM SHALL then go to IDLE.
REQ-032 ld_req while ld_busy SHALL be ignored; a burst SHALL never be preempted by mem_req.
Reset
REQ-033 On R low: state=IDLE, starve_cnt=0, latched burst fields=0, ld_rdata=0, ld_ack/ld_done/ld_busy/mem_stall=0; an in-flight burst SHALL be abandoned with no ld_done.
REQ-034 Reset release SHALL take effect on the next rising clk; no access SHALL be issued during reset.
Structure
REQ-035 The state enum, STARVE_MAX default and address/length widths SHALL live in shared package ppu_pkg.
REQ-036 The address/beat counter SHALL be one sub-module, burst_counter (load, increment-wrap, last-beat flag).
Verification
REQ-037 ld_req, ld_rw=1, ld_addr=0x10, ld_len=3, bytes AA,BB,CC,DD, mem_req=0 -> 4 ld_ack cycles writing 0x10..0x13, ld_done 1 cycle later, readback reads AA..DD.
REQ-038 ld_addr=0xFE, ld_len=2, write -> beats at 0xFE, 0xFF, 0x00.
REQ-039 mem_req held high, ld_req pulsed -> pipeline served 4 cycles, then BURST with mem_stall=1 for ld_len+1 cycles, then mem_stall=0.
REQ-040 MEM-stage word read at 52 in IDLE -> mem_rdata = RAM word at 52 same cycle, ld_ack=0.
REQ-041 R low during beat 2 of a 4-beat burst -> outputs 0 immediately, state IDLE, no ld_done, bytes 3-4 unwritten.
